main_memory_ctrl: RTL and testbench
===================================

MAIN_MEMORY_CTRL -- requirements
Module: main_memory_ctrl

Interface
REQ-001 SHALL have parameter LINE_SIZE, default `L2_LINE_SIZE, line width in bytes; the data buses are LINE_SIZE*8 bits wide.
REQ-002 SHALL have parameter MEM_LINES, default 1024, storage depth in lines (power of two).
REQ-003 SHALL have parameter READ_LATENCY, default 10, cycles from request acceptance to read completion (minimum 1).
REQ-004 SHALL have parameter WRITE_LATENCY, default 10, cycles from request acceptance to write completion (minimum 1).
REQ-005 SHALL have clk  input  1  clock; all state changes on the rising edge.
REQ-006 SHALL have rst_n  input  1  reset, asynchronous, active-low.
REQ-007 SHALL have mem_addr  input  32  byte address of the line.
REQ-008 SHALL have mem_wdata  input  LINE_SIZE*8  write line data.
REQ-009 SHALL have mem_rd  input  1  read request, level, held until mem_ready is seen.
REQ-010 SHALL have mem_wr  input  1  write request, level, held until mem_ready is seen.
REQ-011 SHALL have mem_rdata  output  LINE_SIZE*8  read line data, registered.
REQ-012 SHALL have mem_ready  output  1  one-cycle completion pulse, registered.

Function
REQ-013 SHALL implement states IDLE, BUSY, DONE and RELEASE.
REQ-014 In IDLE, a rising edge that samples mem_rd or mem_wr high SHALL latch the line index, wdata and operation, load the latency counter with the matching latency, and enter BUSY.
REQ-015 The line index SHALL be mem_addr[log2(LINE_SIZE)+log2(MEM_LINES)-1 : log2(LINE_SIZE)]; upper bits are ignored, so addresses wrap modulo MEM_LINES.
REQ-016 mem_rd and mem_wr both high SHALL be treated as a write.
REQ-017 In BUSY the counter SHALL decrement each edge; the edge at which it reaches zero SHALL enter DONE.
REQ-018 On that same edge, a read SHALL load mem_rdata from the array and a write SHALL update the array.
REQ-019 mem_ready SHALL be high for exactly the single cycle spent in DONE.
REQ-020 mem_ready SHALL therefore rise exactly LAT cycles after the accepting edge.
REQ-021 DONE SHALL always advance to RELEASE.
REQ-022 RELEASE SHALL return to IDLE only on an edge sampling mem_rd=0 and mem_wr=0, so a request still held for one cycle after mem_ready is never re-accepted.
REQ-023 Request and data inputs SHALL be ignored outside IDLE.
REQ-024 mem_rdata SHALL hold its last read value through writes and idle periods.
REQ-025 A write followed by a read of the same line SHALL return the written data.
REQ-026 mem_ready SHALL never be asserted unless a request was accepted.

Reset
REQ-027 Asserting rst_n low SHALL immediately force state to IDLE, mem_ready=0, mem_rdata=0 and the counter to 0.
REQ-028 Reset during BUSY SHALL abort the operation, and an aborted write SHALL leave the array unchanged.
REQ-029 Array contents SHALL NOT be affected by reset and SHALL be zero at time zero.

Configuration
REQ-030 Macro MAIN_MEMORY_STATS_EN, when defined, SHALL add outputs rd_count[31:0] and wr_count[31:0].
REQ-031 The counters SHALL increment on each completed read and write respectively, wrap at 2^32, and reset to 0.
REQ-032 When MAIN_MEMORY_STATS_EN is undefined, those ports and counters SHALL be absent and all other behaviour SHALL be identical.

Verification
REQ-033 Read latency: LINE_SIZE=64, READ_LATENCY=4; mem_rd held at 0x0000_0040 from edge 0 -> mem_ready high only during cycle 4 after acceptance, mem_rdata=0 (unwritten line).
REQ-034 Write-then-read: write 0xA5 repeated to 0x0000_1000, release, then read 0x0000_1000 -> mem_rdata=0xA5 repeated; read of 0x0000_1040 returns 0.
REQ-035 Held request: mem_rd kept high one extra cycle after mem_ready -> exactly one mem_ready pulse, state back to IDLE afterwards.
REQ-036 Writeback-then-allocate sequence: write 0x0000_2000, drop mem_wr, assert mem_rd to 0x0001_2000 on the next edge -> two pulses.
REQ-037 Wrap with MEM_LINES=1024: in that sequence the read returns the written line, because 0x0001_2000 aliases 0x0000_2000.
REQ-038 Reset mid-write: rst_n low two cycles into a write of 0xFF.. to 0x80 -> mem_ready stays 0, a later read of 0x80 returns 0.
REQ-039 Stats: with MAIN_MEMORY_STATS_EN, 3 reads and 2 writes (one with rd&wr both high) -> rd_count=3, wr_count=2.

Source files
------------

// File: rtl/main_memory_ctrl.sv
// Fixed-latency line-wide main memory model behind a level request / pulse-ready handshake.
// Optional macro MAIN_MEMORY_STATS_EN adds rd_count / wr_count completion counters.
`ifndef L2_LINE_SIZE
`define L2_LINE_SIZE 64
`endif

module main_memory_ctrl #(
    parameter int LINE_SIZE     = `L2_LINE_SIZE,
    parameter int MEM_LINES     = 1024,
    parameter int READ_LATENCY  = 10,
    parameter int WRITE_LATENCY = 10
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [31:0]            mem_addr,
    input  logic [LINE_SIZE*8-1:0] mem_wdata,
    input  logic                   mem_rd,
    input  logic                   mem_wr,
    output logic [LINE_SIZE*8-1:0] mem_rdata,
    output logic                   mem_ready
`ifdef MAIN_MEMORY_STATS_EN
    ,
    output logic [31:0]            rd_count,
    output logic [31:0]            wr_count
`endif
);

    localparam int LINE_W  = LINE_SIZE * 8;
    localparam int OFF_W   = $clog2(LINE_SIZE);
    localparam int IDX_W   = $clog2(MEM_LINES);
    localparam int LAT_MAX = (READ_LATENCY > WRITE_LATENCY) ? READ_LATENCY : WRITE_LATENCY;
    localparam int CNT_W   = $clog2(LAT_MAX + 1);

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        DONE,
        RELEASE
    } state_t;

    state_t            state;
    state_t            next_state;
    logic [CNT_W-1:0]  lat_cnt;
    logic [IDX_W-1:0]  line_idx;
    logic [LINE_W-1:0] wdata_q;
    logic              op_write;
    logic              accept;
    logic              finish;

    // Power-up contents are all zero; reset deliberately leaves the array alone.
    logic [LINE_W-1:0] mem_array [MEM_LINES] = '{default: '0};

    // Address bits above the index and inside the line are don't-care.
    logic unused_addr_bits;
    assign unused_addr_bits = ^mem_addr;

    // NOTE: every output of this block gets a default first, so no latch can be inferred.
    always_comb begin
        next_state = state;
        accept     = 1'b0;
        finish     = 1'b0;
        case (state)
            IDLE: begin
                if (mem_rd || mem_wr) begin
                    accept     = 1'b1;
                    next_state = BUSY;
                end
            end
            BUSY: begin
                if (lat_cnt == CNT_W'(1)) begin
                    finish     = 1'b1;
                    next_state = DONE;
                end
            end
            DONE:    next_state = RELEASE;
            // A requester still holding its level after mem_ready must not start a new access.
            RELEASE: begin
                if (!mem_rd && !mem_wr) begin
                    next_state = IDLE;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lat_cnt   <= '0;
            line_idx  <= '0;
            op_write  <= 1'b0;
            mem_ready <= 1'b0;
            mem_rdata <= '0;
        end else begin
            mem_ready <= (next_state == DONE);
            if (accept) begin
                // Simultaneous rd and wr resolves to a write.
                op_write <= mem_wr;
                line_idx <= mem_addr[OFF_W +: IDX_W];
                lat_cnt  <= mem_wr ? CNT_W'(WRITE_LATENCY) : CNT_W'(READ_LATENCY);
            end else if (state == BUSY) begin
                lat_cnt <= lat_cnt - CNT_W'(1);
            end
            if (finish && !op_write) begin
                mem_rdata <= mem_array[line_idx];
            end
        end
    end

    // NOTE: the storage array and its write-data holding register carry no reset; an aborted
    // write is harmless because finish can only fire from BUSY, which reset leaves at once.
    always_ff @(posedge clk) begin
        if (accept) begin
            wdata_q <= mem_wdata;
        end
        if (finish && op_write) begin
            mem_array[line_idx] <= wdata_q;
        end
    end

`ifdef MAIN_MEMORY_STATS_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_count <= '0;
            wr_count <= '0;
        end else if (finish) begin
            if (op_write) begin
                wr_count <= wr_count + 32'd1;
            end else begin
                rd_count <= rd_count + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_main_memory_ctrl.sv
// Randomized self-checking bench for main_memory_ctrl against an address-indexed line model.
`timescale 1ns/1ps

module tb_main_memory_ctrl;

    localparam int LINE_SIZE = 64;
    localparam int MEM_LINES = 1024;
    localparam int RL        = 4;
    localparam int WL        = 5;
    localparam int LW        = LINE_SIZE * 8;
    localparam int LAT_MAX   = (RL > WL) ? RL : WL;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [31:0]   mem_addr;
    logic [LW-1:0] mem_wdata;
    logic          mem_rd;
    logic          mem_wr;
    logic [LW-1:0] mem_rdata;
    logic          mem_ready;
`ifdef MAIN_MEMORY_STATS_EN
    logic [31:0]   rd_count;
    logic [31:0]   wr_count;
`endif

    int checks = 0;
    int errors = 0;

    // Reference: line contents by line number, absent lines read as zero.
    logic [LW-1:0] model [int];
    logic [LW-1:0] last_rd;

    main_memory_ctrl #(
        .LINE_SIZE    (LINE_SIZE),
        .MEM_LINES    (MEM_LINES),
        .READ_LATENCY (RL),
        .WRITE_LATENCY(WL)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .mem_addr (mem_addr),
        .mem_wdata(mem_wdata),
        .mem_rd   (mem_rd),
        .mem_wr   (mem_wr),
        .mem_rdata(mem_rdata),
        .mem_ready(mem_ready)
`ifdef MAIN_MEMORY_STATS_EN
        ,
        .rd_count (rd_count),
        .wr_count (wr_count)
`endif
    );

    always #5 clk = ~clk;

    function automatic logic [LW-1:0] rand_line();
        logic [LW-1:0] v;
        for (int i = 0; i < LW / 32; i++) v[i*32 +: 32] = $urandom;
        return v;
    endfunction

    function automatic int line_of(input logic [31:0] addr);
        return int'((addr / 32'(LINE_SIZE)) % 32'(MEM_LINES));
    endfunction

    function automatic logic [LW-1:0] model_rd(input int idx);
        return model.exists(idx) ? model[idx] : '0;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        mem_rd = 1'b0; mem_wr = 1'b0;
        rst_n = 1'b0;
        repeat (2) step();
        rst_n = 1'b1;
        last_rd = '0;
        step();
    endtask

    // One full handshake: drive, wait for the pulse, optionally keep holding, then release.
    task automatic do_txn(input bit rd, input bit wr, input logic [31:0] addr,
                          input logic [LW-1:0] wdata, input int hold, input string name);
        int            lat;
        int            cycles;
        int            spurious;
        int            unstable;
        int            idx;
        logic [LW-1:0] exp;
        lat = wr ? WL : RL;
        idx = line_of(addr);
        mem_rd = rd; mem_wr = wr; mem_addr = addr; mem_wdata = wdata;
        step();
        cycles = 0;
        while (mem_ready !== 1'b1 && cycles < 100) begin
            mem_addr  = $urandom;
            mem_wdata = rand_line();
            step();
            cycles++;
        end
        checks++;
        if (cycles !== lat) begin
            errors++;
            $display("FAIL %s latency: got %0d cycles, want %0d", name, cycles, lat);
        end
        if (wr) begin
            model[idx] = wdata;
            exp = last_rd;
        end else begin
            exp = model_rd(idx);
            last_rd = exp;
        end
        checks++;
        if (mem_rdata !== exp) begin
            errors++;
            $display("FAIL %s rdata: got %h want %h", name, mem_rdata, exp);
        end
        spurious = 0;
        unstable = 0;
        for (int h = 0; h < hold; h++) begin
            step();
            if (mem_ready !== 1'b0) spurious++;
        end
        mem_rd = 1'b0; mem_wr = 1'b0;
        for (int k = 0; k < LAT_MAX + 3; k++) begin
            step();
            if (mem_ready !== 1'b0) spurious++;
            if (mem_rdata !== exp) unstable++;
        end
        checks++;
        if (spurious !== 0) begin
            errors++;
            $display("FAIL %s extra_ready: got %0d extra pulse cycles, want 0", name, spurious);
        end
        checks++;
        if (unstable !== 0) begin
            errors++;
            $display("FAIL %s rdata_hold: got %0d changed cycles, want 0", name, unstable);
        end
    endtask

    task automatic test_reset();
        mem_rd = 1'b1; mem_wr = 1'b1;
        mem_addr = $urandom; mem_wdata = rand_line();
        rst_n = 1'b0;
        #3;
        checks++;
        if (mem_ready !== 1'b0 || mem_rdata !== '0) begin
            errors++;
            $display("FAIL reset_async: got ready=%b rdata=%h want 0/0", mem_ready, mem_rdata);
        end
        repeat (3) step();
        checks++;
        if (mem_ready !== 1'b0 || mem_rdata !== '0) begin
            errors++;
            $display("FAIL reset_hold: got ready=%b rdata=%h want 0/0", mem_ready, mem_rdata);
        end
        mem_rd = 1'b0; mem_wr = 1'b0;
        rst_n = 1'b1;
        last_rd = '0;
        repeat (LAT_MAX + 3) step();
        checks++;
        if (mem_ready !== 1'b0) begin
            errors++;
            $display("FAIL reset_idle_ready: got %b want 0", mem_ready);
        end
    endtask

    task automatic test_read_latency();
        do_txn(1'b1, 1'b0, 32'h0000_0040, '0, 0, "read_latency");
    endtask

    task automatic test_write_read();
        do_txn(1'b0, 1'b1, 32'h0000_1000, {LINE_SIZE{8'hA5}}, 0, "wr_a5");
        do_txn(1'b1, 1'b0, 32'h0000_1000, '0, 0, "rd_a5");
        checks++;
        if (mem_rdata !== {LINE_SIZE{8'hA5}}) begin
            errors++;
            $display("FAIL rd_a5_pattern: got %h want a5 repeated", mem_rdata);
        end
        do_txn(1'b1, 1'b0, 32'h0000_1040, '0, 0, "rd_1040");
    endtask

    task automatic test_held_request();
        do_txn(1'b1, 1'b0, 32'h0000_1000, '0, 1, "held_1");
        do_txn(1'b1, 1'b0, 32'h0000_1000, '0, 4, "held_4");
        do_txn(1'b0, 1'b1, 32'h0000_3000, rand_line(), 3, "held_wr");
        do_txn(1'b1, 1'b0, 32'h0000_3000, '0, 0, "after_held");
    endtask

    task automatic test_alias();
        logic [LW-1:0] d;
        d = rand_line();
        do_txn(1'b0, 1'b1, 32'h0000_2000, d, 0, "alias_wr");
        do_txn(1'b1, 1'b0, 32'h0001_2000, '0, 0, "alias_rd");
        checks++;
        if (mem_rdata !== d) begin
            errors++;
            $display("FAIL alias_data: got %h want %h", mem_rdata, d);
        end
    endtask

    task automatic test_reset_mid_write();
        int pulses;
        mem_wr = 1'b1; mem_rd = 1'b0;
        mem_addr = 32'h0000_0080; mem_wdata = {LW{1'b1}};
        step();
        repeat (2) step();
        mem_wr = 1'b0;
        rst_n = 1'b0;
        #1;
        checks++;
        if (mem_ready !== 1'b0 || mem_rdata !== '0) begin
            errors++;
            $display("FAIL midwr_reset: got ready=%b rdata=%h want 0/0", mem_ready, mem_rdata);
        end
        repeat (2) step();
        rst_n = 1'b1;
        last_rd = '0;
        pulses = 0;
        for (int k = 0; k < WL + 4; k++) begin
            step();
            if (mem_ready !== 1'b0) pulses++;
        end
        checks++;
        if (pulses !== 0) begin
            errors++;
            $display("FAIL midwr_ready: got %0d pulse cycles want 0", pulses);
        end
        do_txn(1'b1, 1'b0, 32'h0000_0080, '0, 0, "midwr_readback");
    endtask

    task automatic test_random();
        for (int n = 0; n < 60; n++) begin
            logic [31:0] a;
            bit          rd;
            bit          wr;
            int          sel;
            a   = $urandom;
            a   = (a & 32'hFFFF_003F) | (32'($urandom_range(0, 15)) << 6);
            sel = $urandom_range(0, 3);
            rd  = (sel == 0 || sel == 2);
            wr  = (sel == 1 || sel == 2);
            if (sel == 3) rd = 1'b1;
            do_txn(rd, wr, a, rand_line(), $urandom_range(0, 2), $sformatf("rand%0d", n));
        end
    endtask

`ifdef MAIN_MEMORY_STATS_EN
    task automatic test_stats();
        apply_reset();
        checks++;
        if (rd_count !== 32'd0 || wr_count !== 32'd0) begin
            errors++;
            $display("FAIL stats_reset: got rd=%0d wr=%0d want 0/0", rd_count, wr_count);
        end
        do_txn(1'b1, 1'b0, 32'h0000_0100, '0, 0, "st_rd0");
        do_txn(1'b0, 1'b1, 32'h0000_0100, rand_line(), 0, "st_wr0");
        do_txn(1'b1, 1'b1, 32'h0000_0140, rand_line(), 1, "st_wr1");
        do_txn(1'b1, 1'b0, 32'h0000_0100, '0, 0, "st_rd1");
        do_txn(1'b1, 1'b0, 32'h0000_0140, '0, 0, "st_rd2");
        checks++;
        if (rd_count !== 32'd3 || wr_count !== 32'd2) begin
            errors++;
            $display("FAIL stats_count: got rd=%0d wr=%0d want 3/2", rd_count, wr_count);
        end
    endtask
`endif

    initial begin
        rst_n = 1'b0;
        mem_rd = 1'b0; mem_wr = 1'b0;
        mem_addr = '0; mem_wdata = '0;
        last_rd = '0;
        #2;
        test_reset();
        test_read_latency();
        test_write_read();
        test_held_request();
        test_alias();
        test_reset_mid_write();
        test_random();
`ifdef MAIN_MEMORY_STATS_EN
        test_stats();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
